polygon_frame_loader: RTL

Double-buffered polygon table that feeds the per-slot draw_polygon instances. A world/physics requester writes polygon vertices into a shadow bank over a valid/ready port, then commits. The loader swaps shadow into the active bank only on the next frame-start pulse, and latches the camera position at the same instant, so every rasterized frame sees one consistent polygon set and camera. Sits between the game-logic update path and the draw_polygon array in the video pipeline.

---
 rtl/polygon_frame_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/polygon_frame_loader.sv
// Double-buffered polygon table: writes land in a shadow bank, a commit arms a
// swap, and the next frame-start copies shadow to active and latches the camera.
module polygon_frame_loader #(
    parameter int NUM_SLOTS        = 8,
    parameter int MAX_NUM_VERTICES = 4,
    localparam int SW  = $clog2(NUM_SLOTS),
    localparam int VW  = $clog2(MAX_NUM_VERTICES),
    localparam int NPW = VW + 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    frame_start_in,
    input  logic                    wr_valid_in,
    output logic                    wr_ready_out,
    input  logic [SW-1:0]           wr_slot_in,
    input  logic [VW-1:0]           wr_vertex_in,
    input  logic signed [31:0]      wr_x_in,
    input  logic signed [31:0]      wr_y_in,
    input  logic                    wr_last_in,
    input  logic                    commit_valid_in,
    output logic                    commit_ready_out,
    input  logic [31:0]             camera_x_in,
    input  logic [31:0]             camera_y_in,
    output logic signed [31:0]      xs_out [NUM_SLOTS][MAX_NUM_VERTICES],
    output logic signed [31:0]      ys_out [NUM_SLOTS][MAX_NUM_VERTICES],
    output logic [NPW-1:0]          num_points_out [NUM_SLOTS],
    output logic [NUM_SLOTS-1:0]    slot_en_out,
    output logic [31:0]             camera_x_out,
    output logic [31:0]             camera_y_out,
    output logic                    swap_out,
    output logic                    err_out,
    output logic                    fsm_state_out
);

    // Handshakes: a transfer happens on a rising clk_in edge where valid and
    // ready are both high; ready depends only on the FSM state, never on valid.
    typedef enum logic {ST_LOAD = 1'b0, ST_PENDING = 1'b1} state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_swap;
    logic   w_wr_fire;
    logic   w_vertex_bad;
    logic   w_short;

    logic signed [31:0]   r_sh_x  [NUM_SLOTS][MAX_NUM_VERTICES];
    logic signed [31:0]   r_sh_y  [NUM_SLOTS][MAX_NUM_VERTICES];
    logic [NPW-1:0]       r_sh_np [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] r_sh_en;

    assign fsm_state_out = r_state;
    assign w_wr_fire     = wr_valid_in & wr_ready_out;
    assign w_vertex_bad  = {1'b0, wr_vertex_in} >= NPW'(MAX_NUM_VERTICES);
    assign w_short       = {1'b0, wr_vertex_in} < NPW'(2);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= ST_LOAD;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state     = r_state;
        wr_ready_out     = 1'b0;
        commit_ready_out = 1'b0;
        w_swap           = 1'b0;
        case (r_state)
            ST_LOAD: begin
                wr_ready_out     = 1'b1;
                commit_ready_out = 1'b1;
                if (commit_valid_in) w_next_state = ST_PENDING;
            end
            ST_PENDING: begin
                if (frame_start_in) begin
                    w_next_state = ST_LOAD;
                    w_swap       = 1'b1;
                end
            end
            default: w_next_state = ST_LOAD;
        endcase
    end

    // Shadow bank survives commits so the requester can update slots incrementally.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                for (int v = 0; v < MAX_NUM_VERTICES; v++) begin
                    r_sh_x[s][v] <= '0;
                    r_sh_y[s][v] <= '0;
                end
                r_sh_np[s] <= '0;
            end
            r_sh_en <= '0;
        end else if (w_wr_fire && !w_vertex_bad) begin
            r_sh_x[wr_slot_in][wr_vertex_in] <= wr_x_in;
            r_sh_y[wr_slot_in][wr_vertex_in] <= wr_y_in;
            if (wr_last_in) begin
                if (w_short) begin
                    r_sh_np[wr_slot_in] <= '0;
                    r_sh_en[wr_slot_in] <= 1'b0;
                end else begin
                    r_sh_np[wr_slot_in] <= NPW'(wr_vertex_in) + NPW'(1);
                    r_sh_en[wr_slot_in] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                for (int v = 0; v < MAX_NUM_VERTICES; v++) begin
                    xs_out[s][v] <= '0;
                    ys_out[s][v] <= '0;
                end
                num_points_out[s] <= '0;
            end
            slot_en_out  <= '0;
            camera_x_out <= '0;
            camera_y_out <= '0;
            swap_out     <= 1'b0;
            err_out      <= 1'b0;
        end else begin
            swap_out <= w_swap;
            err_out  <= w_wr_fire && (w_vertex_bad || (wr_last_in && w_short));
            if (w_swap) begin
                xs_out         <= r_sh_x;
                ys_out         <= r_sh_y;
                num_points_out <= r_sh_np;
                slot_en_out    <= r_sh_en;
                camera_x_out   <= camera_x_in;
                camera_y_out   <= camera_y_in;
            end
        end
    end

endmodule
